// File: rtl/sram_responder.sv
// On-chip emulation of a 16-bit async SRAM with a byte-stream program loader.
// Optional `SRAM_ACCESS_CNT_EN adds read/write access counters.
module sram_responder #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              sw,
  input  logic              i_SRAM_CE_N,
  input  logic              i_SRAM_OE_N,
  input  logic              i_SRAM_WE_N,
  input  logic              i_SRAM_LB_N,
  input  logic              i_SRAM_UB_N,
  input  logic [19:0]       i_SRAM_ADDR,
  inout  wire  [15:0]       io_SRAM_DQ,
  input  logic              i_load_mode,
  input  logic              i_load_valid,
  input  logic [7:0]        i_load_byte,
  output logic              o_load_ready,
  output logic              o_busy,
  output logic              o_load_ovf,
`ifdef SRAM_ACCESS_CNT_EN
  output logic [31:0]       o_rd_count,
  output logic [31:0]       o_wr_count,
`endif
  output logic [ADDR_W:0]   o_load_count
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_LOAD_HI = 2'd1;
  localparam logic [1:0] ST_LOAD_LO = 2'd2;
  localparam logic [1:0] ST_FLUSH   = 2'd3;

  logic [7:0]        mem_hi [DEPTH];
  logic [7:0]        mem_lo [DEPTH];
  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [ADDR_W-1:0] ptr;
  logic [7:0]        hi_byte;
  logic [ADDR_W-1:0] cpu_idx;
  logic              cpu_rd;
  logic              cpu_wr;
  logic              load_accept;
  logic              ld_wr;
  logic [7:0]        ld_lo;
  logic [15:0]       rd_data;
  logic [ADDR_W:0]   count_max;
  wire               unused_addr = &{1'b0, i_SRAM_ADDR[19:ADDR_W]};

  assign count_max = {1'b1, {ADDR_W{1'b0}}};
  assign cpu_idx   = i_SRAM_ADDR[ADDR_W-1:0];

  // CPU pins are only honoured in RUN; WE_N low always wins over OE_N.
  assign cpu_rd = (state == ST_RUN) & ~i_SRAM_CE_N & ~i_SRAM_OE_N & i_SRAM_WE_N;
  assign cpu_wr = (state == ST_RUN) & ~i_SRAM_CE_N & ~i_SRAM_WE_N;

  assign rd_data    = {i_SRAM_UB_N ? 8'h00 : mem_hi[cpu_idx],
                       i_SRAM_LB_N ? 8'h00 : mem_lo[cpu_idx]};
  assign io_SRAM_DQ = cpu_rd ? rd_data : 16'hzzzz;

  assign o_load_ready = i_load_mode & ((state == ST_LOAD_HI) | (state == ST_LOAD_LO));
  assign load_accept  = i_load_valid & o_load_ready;
  assign ld_wr        = ((state == ST_LOAD_LO) & load_accept) | (state == ST_FLUSH);
  assign ld_lo        = (state == ST_FLUSH) ? 8'h00 : i_load_byte;

  always_ff @(posedge clk) begin
    if (ld_wr) begin
      mem_hi[ptr] <= hi_byte;
      mem_lo[ptr] <= ld_lo;
    end else if (cpu_wr) begin
      if (!i_SRAM_UB_N) mem_hi[cpu_idx] <= io_SRAM_DQ[15:8];
      if (!i_SRAM_LB_N) mem_lo[cpu_idx] <= io_SRAM_DQ[7:0];
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:     if (i_load_mode) state_next = ST_LOAD_HI;
      ST_LOAD_HI: if (!i_load_mode) state_next = ST_RUN;
                  else if (load_accept) state_next = ST_LOAD_LO;
      ST_LOAD_LO: if (!i_load_mode) state_next = ST_FLUSH;
                  else if (load_accept) state_next = ST_LOAD_HI;
      default:    state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge sw) begin
    if (!sw) begin
      state        <= ST_RUN;
      o_busy       <= 1'b0;
      ptr          <= '0;
      hi_byte      <= 8'h00;
      o_load_ovf   <= 1'b0;
      o_load_count <= '0;
    end else begin
      state  <= state_next;
      o_busy <= (state_next != ST_RUN);
      if ((state == ST_RUN) && i_load_mode) begin
        ptr          <= '0;
        o_load_count <= '0;
        o_load_ovf   <= 1'b0;
      end
      if ((state == ST_LOAD_HI) && load_accept) hi_byte <= i_load_byte;
      if (ld_wr) begin
        ptr <= ptr + 1'b1;
        if (ptr == {ADDR_W{1'b1}}) o_load_ovf <= 1'b1;
        if (o_load_count != count_max) o_load_count <= o_load_count + 1'b1;
      end
    end
  end

`ifdef SRAM_ACCESS_CNT_EN
  always_ff @(posedge clk or negedge sw) begin
    if (!sw) begin
      o_rd_count <= 32'd0;
      o_wr_count <= 32'd0;
    end else begin
      if (cpu_rd) o_rd_count <= o_rd_count + 32'd1;
      if (cpu_wr) o_wr_count <= o_wr_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Directed self-checking bench for sram_responder (default depth plus a 4-entry instance).
`timescale 1ns/1ps
module tb_sram_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        sw;
  logic        ce_n, oe_n, we_n, lb_n, ub_n;
  logic [19:0] addr;
  logic [15:0] dq_drv;
  logic        dq_en;
  wire  [15:0] dq;
  logic        load_mode, load_valid;
  logic [7:0]  load_byte;
  logic        load_ready, busy, load_ovf;
  logic [10:0] load_count;
`ifdef SRAM_ACCESS_CNT_EN
  logic [31:0] rd_count, wr_count;
  logic [31:0] s_rd_count, s_wr_count;
`endif

  logic        s_ce_n, s_oe_n, s_we_n, s_lb_n, s_ub_n;
  logic [19:0] s_addr;
  logic [15:0] s_dq_drv;
  logic        s_dq_en;
  wire  [15:0] s_dq;
  logic        s_load_mode, s_load_valid;
  logic [7:0]  s_load_byte;
  logic        s_load_ready, s_busy, s_load_ovf;
  logic [2:0]  s_load_count;

  assign dq   = dq_en   ? dq_drv   : 16'hzzzz;
  assign s_dq = s_dq_en ? s_dq_drv : 16'hzzzz;

  int checks = 0;
  int errors = 0;

  sram_responder #(.ADDR_W(10)) dut (
    .clk(clk), .sw(sw),
    .i_SRAM_CE_N(ce_n), .i_SRAM_OE_N(oe_n), .i_SRAM_WE_N(we_n),
    .i_SRAM_LB_N(lb_n), .i_SRAM_UB_N(ub_n), .i_SRAM_ADDR(addr), .io_SRAM_DQ(dq),
    .i_load_mode(load_mode), .i_load_valid(load_valid), .i_load_byte(load_byte),
    .o_load_ready(load_ready), .o_busy(busy), .o_load_ovf(load_ovf),
`ifdef SRAM_ACCESS_CNT_EN
    .o_rd_count(rd_count), .o_wr_count(wr_count),
`endif
    .o_load_count(load_count)
  );

  sram_responder #(.ADDR_W(2)) dut_small (
    .clk(clk), .sw(sw),
    .i_SRAM_CE_N(s_ce_n), .i_SRAM_OE_N(s_oe_n), .i_SRAM_WE_N(s_we_n),
    .i_SRAM_LB_N(s_lb_n), .i_SRAM_UB_N(s_ub_n), .i_SRAM_ADDR(s_addr), .io_SRAM_DQ(s_dq),
    .i_load_mode(s_load_mode), .i_load_valid(s_load_valid), .i_load_byte(s_load_byte),
    .o_load_ready(s_load_ready), .o_busy(s_busy), .o_load_ovf(s_load_ovf),
`ifdef SRAM_ACCESS_CNT_EN
    .o_rd_count(s_rd_count), .o_wr_count(s_wr_count),
`endif
    .o_load_count(s_load_count)
  );

  task automatic cpu_write(input logic [19:0] a, input logic [15:0] d,
                           input logic ub, input logic lb, input logic oe);
    @(negedge clk);
    addr = a; dq_drv = d; dq_en = 1'b1; ub_n = ub; lb_n = lb; oe_n = oe; we_n = 1'b0; ce_n = 1'b0;
    @(posedge clk); #1;
    ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1; dq_en = 1'b0;
  endtask

  // Read completes inside one low clock phase, so no clock edge sees it.
  task automatic cpu_read(input logic [19:0] a, input logic ub, input logic lb,
                          output logic [15:0] d);
    @(negedge clk);
    addr = a; ub_n = ub; lb_n = lb; we_n = 1'b1; oe_n = 1'b0; ce_n = 1'b0;
    #1 d = dq;
    ce_n = 1'b1; oe_n = 1'b1;
  endtask

  task automatic s_cpu_write(input logic [19:0] a, input logic [15:0] d);
    @(negedge clk);
    s_addr = a; s_dq_drv = d; s_dq_en = 1'b1; s_ub_n = 1'b0; s_lb_n = 1'b0; s_we_n = 1'b0; s_ce_n = 1'b0;
    @(posedge clk); #1;
    s_ce_n = 1'b1; s_we_n = 1'b1; s_dq_en = 1'b0;
  endtask

  task automatic s_cpu_read(input logic [19:0] a, output logic [15:0] d);
    @(negedge clk);
    s_addr = a; s_ub_n = 1'b0; s_lb_n = 1'b0; s_we_n = 1'b1; s_oe_n = 1'b0; s_ce_n = 1'b0;
    #1 d = s_dq;
    s_ce_n = 1'b1; s_oe_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    load_valid = 1'b1; load_byte = b; n = 0;
    @(negedge clk);
    while (!load_ready && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (load_ready !== 1'b1) begin
      errors++; $display("FAIL send_byte_ready byte=%h got=%b want=1", b, load_ready);
    end
    @(posedge clk); #1;
    load_valid = 1'b0;
  endtask

  task automatic s_send_byte(input logic [7:0] b);
    int n;
    s_load_valid = 1'b1; s_load_byte = b; n = 0;
    @(negedge clk);
    while (!s_load_ready && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (s_load_ready !== 1'b1) begin
      errors++; $display("FAIL s_send_byte_ready byte=%h got=%b want=1", b, s_load_ready);
    end
    @(posedge clk); #1;
    s_load_valid = 1'b0;
  endtask

  task automatic test_reset();
    sw = 1'b0; load_mode = 1'b1; #12;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b want=0", load_ready); end
    checks++; if (load_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b want=0", load_ovf); end
    checks++; if (load_count !== 11'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", load_count); end
    load_mode = 1'b0;
    @(negedge clk); sw = 1'b1;
    $display("reset done busy=%b count=%0d", busy, load_count);
  endtask

  task automatic test_write_read();
    logic [15:0] d;
    cpu_write(20'd5, 16'hBEEF, 1'b0, 1'b0, 1'b1);
    cpu_read(20'd5, 1'b0, 1'b0, d);
    checks++; if (d !== 16'hBEEF) begin errors++; $display("FAIL write_read got=%h want=beef", d); end
    $display("write/read addr=5 data=%h", d);
  endtask

  task automatic test_lanes();
    logic [15:0] d;
    cpu_write(20'd5, 16'h12AB, 1'b0, 1'b1, 1'b0);
    cpu_read(20'd5, 1'b0, 1'b0, d);
    checks++; if (d !== 16'h12EF) begin errors++; $display("FAIL upper_lane_write got=%h want=12ef", d); end
    cpu_read(20'd5, 1'b1, 1'b0, d);
    checks++; if (d !== 16'h00EF) begin errors++; $display("FAIL ub_disabled_read got=%h want=00ef", d); end
    cpu_read(20'd5, 1'b0, 1'b1, d);
    checks++; if (d !== 16'h1200) begin errors++; $display("FAIL lb_disabled_read got=%h want=1200", d); end
    cpu_write(20'd5, 16'h7777, 1'b1, 1'b1, 1'b1);
    cpu_read(20'd5, 1'b0, 1'b0, d);
    checks++; if (d !== 16'h12EF) begin errors++; $display("FAIL no_lane_write got=%h want=12ef", d); end
    $display("lane tests addr=5 final=%h", d);
  endtask

  task automatic test_alias();
    logic [15:0] d;
    cpu_write(20'hFFC07, 16'hA55A, 1'b0, 1'b0, 1'b1);
    cpu_read(20'd7, 1'b0, 1'b0, d);
    checks++; if (d !== 16'hA55A) begin errors++; $display("FAIL alias_low got=%h want=a55a", d); end
    cpu_read(20'h00407, 1'b0, 1'b0, d);
    checks++; if (d !== 16'hA55A) begin errors++; $display("FAIL alias_high got=%h want=a55a", d); end
    $display("alias addr=7 data=%h", d);
  endtask

  task automatic test_load_even();
    logic [15:0] d;
    @(negedge clk); load_mode = 1'b1; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_before_edge got=%b want=0", busy); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_edge got=%b want=1", busy); end
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    checks++; if (load_count !== 11'd2) begin errors++; $display("FAIL even_count_busy got=%0d want=2", load_count); end
    @(negedge clk); load_mode = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL even_busy_end got=%b want=0", busy); end
    cpu_read(20'd0, 1'b0, 1'b0, d);
    checks++; if (d !== 16'hDEAD) begin errors++; $display("FAIL even_mem0 got=%h want=dead", d); end
    cpu_read(20'd1, 1'b0, 1'b0, d);
    checks++; if (d !== 16'hBEEF) begin errors++; $display("FAIL even_mem1 got=%h want=beef", d); end
    checks++; if (load_count !== 11'd2) begin errors++; $display("FAIL even_count got=%0d want=2", load_count); end
    $display("even load count=%0d mem1=%h", load_count, d);
  endtask

  task automatic test_load_odd();
    logic [15:0] d;
    @(negedge clk); load_mode = 1'b1;
    @(posedge clk); #1;
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    checks++; if (load_count !== 11'd1) begin errors++; $display("FAIL odd_count_mid got=%0d want=1", load_count); end
    @(negedge clk); load_mode = 1'b0; load_valid = 1'b1; load_byte = 8'h99; #1;
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL odd_ready_mode_low got=%b want=0", load_ready); end
    @(posedge clk); #1; load_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy got=%b want=1", busy); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_done_busy got=%b want=0", busy); end
    checks++; if (load_count !== 11'd2) begin errors++; $display("FAIL odd_count got=%0d want=2", load_count); end
    cpu_read(20'd0, 1'b0, 1'b0, d);
    checks++; if (d !== 16'hAABB) begin errors++; $display("FAIL odd_mem0 got=%h want=aabb", d); end
    cpu_read(20'd1, 1'b0, 1'b0, d);
    checks++; if (d !== 16'hCC00) begin errors++; $display("FAIL odd_mem1 got=%h want=cc00", d); end
    $display("odd load count=%0d mem1=%h", load_count, d);
  endtask

  task automatic test_write_at_load_start();
    logic [15:0] d;
    @(negedge clk);
    addr = 20'd9; dq_drv = 16'h9999; dq_en = 1'b1; ub_n = 1'b0; lb_n = 1'b0; we_n = 1'b0; ce_n = 1'b0;
    load_mode = 1'b1;
    @(posedge clk); #1;
    ce_n = 1'b1; we_n = 1'b1; dq_en = 1'b0;
    @(negedge clk); load_mode = 1'b0;
    @(posedge clk); #1;
    checks++; if (load_count !== 11'd0) begin errors++; $display("FAIL start_count_cleared got=%0d want=0", load_count); end
    cpu_read(20'd9, 1'b0, 1'b0, d);
    checks++; if (d !== 16'h9999) begin errors++; $display("FAIL write_at_load_start got=%h want=9999", d); end
    $display("write at load start addr=9 data=%h", d);
  endtask

  task automatic test_overflow();
    logic [15:0] d;
    @(negedge clk); s_load_mode = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) s_cpu_write(20'd1, 16'hFFFF);
      s_send_byte(8'h10 + 8'(i));
      if (i == 5) begin
        checks++; if (s_load_ovf !== 1'b0) begin errors++; $display("FAIL ovf_early got=%b want=0", s_load_ovf); end
      end
      if (i == 7) begin
        checks++; if (s_load_ovf !== 1'b1) begin errors++; $display("FAIL ovf_after_byte8 got=%b want=1", s_load_ovf); end
      end
    end
    @(negedge clk); s_load_mode = 1'b0;
    @(posedge clk); #1;
    checks++; if (s_load_count !== 3'd4) begin errors++; $display("FAIL ovf_count_sat got=%0d want=4", s_load_count); end
    s_cpu_read(20'd0, d);
    checks++; if (d !== 16'h1819) begin errors++; $display("FAIL ovf_mem0 got=%h want=1819", d); end
    s_cpu_read(20'd1, d);
    checks++; if (d !== 16'h1213) begin errors++; $display("FAIL busy_write_ignored got=%h want=1213", d); end
    s_cpu_read(20'd3, d);
    checks++; if (d !== 16'h1617) begin errors++; $display("FAIL ovf_mem3 got=%h want=1617", d); end
    @(negedge clk); s_load_mode = 1'b1;
    @(posedge clk); #1;
    checks++; if (s_load_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear_on_start got=%b want=0", s_load_ovf); end
    @(negedge clk); s_load_mode = 1'b0;
    @(posedge clk); #1;
    $display("overflow load count=%0d ovf=%b", s_load_count, s_load_ovf);
  endtask

  task automatic test_reset_in_load();
    logic [15:0] d;
    @(negedge clk); load_mode = 1'b1;
    @(posedge clk); #1;
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77);
    @(negedge clk); #1; sw = 1'b0; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_load_busy got=%b want=0", busy); end
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL rst_load_ready got=%b want=0", load_ready); end
    checks++; if (load_count !== 11'd0) begin errors++; $display("FAIL rst_load_count got=%0d want=0", load_count); end
`ifdef SRAM_ACCESS_CNT_EN
    checks++; if (rd_count !== 32'd0 || wr_count !== 32'd0) begin
      errors++; $display("FAIL rst_counters got=%0d/%0d want=0/0", rd_count, wr_count);
    end
`endif
    load_mode = 1'b0;
    @(negedge clk); sw = 1'b1;
    cpu_read(20'd0, 1'b0, 1'b0, d);
    checks++; if (d !== 16'h5566) begin errors++; $display("FAIL rst_mem0_kept got=%h want=5566", d); end
    cpu_read(20'd1, 1'b0, 1'b0, d);
    checks++; if (d !== 16'hCC00) begin errors++; $display("FAIL rst_mem1_untouched got=%h want=cc00", d); end
    $display("reset in load mem0 kept, mem1=%h", d);
  endtask

`ifdef SRAM_ACCESS_CNT_EN
  task automatic test_counters();
    cpu_write(20'd10, 16'h0A0A, 1'b0, 1'b0, 1'b1);
    cpu_write(20'd11, 16'h0B0B, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    addr = 20'd10; ub_n = 1'b0; lb_n = 1'b0; we_n = 1'b1; oe_n = 1'b0; ce_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 ce_n = 1'b1; oe_n = 1'b1;
    checks++; if (wr_count !== 32'd2) begin errors++; $display("FAIL wr_count got=%0d want=2", wr_count); end
    checks++; if (rd_count !== 32'd3) begin errors++; $display("FAIL rd_count got=%0d want=3", rd_count); end
    $display("counters rd=%0d wr=%0d", rd_count, wr_count);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    ce_n = 1'b1; oe_n = 1'b1; we_n = 1'b1; lb_n = 1'b1; ub_n = 1'b1; addr = '0;
    dq_drv = '0; dq_en = 1'b0; load_mode = 1'b0; load_valid = 1'b0; load_byte = '0;
    s_ce_n = 1'b1; s_oe_n = 1'b1; s_we_n = 1'b1; s_lb_n = 1'b1; s_ub_n = 1'b1; s_addr = '0;
    s_dq_drv = '0; s_dq_en = 1'b0; s_load_mode = 1'b0; s_load_valid = 1'b0; s_load_byte = '0;
    test_reset();
    test_write_read();
    test_lanes();
    test_alias();
    test_load_even();
    test_load_odd();
    test_write_at_load_start();
    test_overflow();
    test_reset_in_load();
`ifdef SRAM_ACCESS_CNT_EN
    test_counters();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
